// File: rtl/lms_err_monitor.sv
// Block mean-squared-error monitor for an LMS adaptive filter: squares error samples,
// averages them over 2^LOGN-sample blocks and tracks acquiring/converged/diverged status.
module lms_err_monitor #(
  parameter int              W2      = 16,
  parameter int              LOGN    = 4,
  parameter int              HOLD    = 4,
  parameter logic [2*W2-1:0] DIV_LIM = (2*W2)'(64'd1 << 28)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 restart,
  input  logic signed [W2-1:0] e_in,
  input  logic [2*W2-1:0]      thr_in,
  output logic [2*W2-1:0]      mse_out,
  output logic                 mse_valid,
  output logic                 converged,
  output logic                 diverged,
  output logic [1:0]           state_out,
  output logic [7:0]           blk_cnt
);
  localparam int MW = 2 * W2;
  localparam int AW = 2 * W2 + LOGN;

  typedef enum logic [1:0] {
    ST_ACQ  = 2'b00,
    ST_CONV = 2'b01,
    ST_DIV  = 2'b10
  } state_t;

  // Stage 1: squared sample
  logic              v1_q, v1_d;
  logic [MW-1:0]     sq_q, sq_d;
  // Stage 2: block accumulation
  logic [AW-1:0]     acc_q, acc_d;
  logic [LOGN-1:0]   scnt_q, scnt_d;
  logic              pend_q, pend_d;
  logic [MW-1:0]     mse_p_q, mse_p_d;
  logic              div_p_q, div_p_d;
  logic              le_p_q, le_p_d;
  // Stage 3: published result and status
  state_t            state_q, state_d;
  logic [3:0]        good_cnt_q, good_cnt_d;
  logic [MW-1:0]     mse_q, mse_d;
  logic              mse_valid_q, mse_valid_d;
  logic [7:0]        blk_cnt_q, blk_cnt_d;

  logic signed [MW-1:0] e_ext;
  logic signed [MW-1:0] prod;
  logic [AW-1:0]        blk_sum;
  logic [MW-1:0]        blk_mse;

  always_comb begin
    e_ext   = MW'(e_in);
    prod    = e_ext * e_ext;
    blk_sum = acc_q + AW'(sq_q);
    blk_mse = MW'(blk_sum >> LOGN);

    v1_d        = en;
    sq_d        = MW'(prod);
    acc_d       = acc_q;
    scnt_d      = scnt_q;
    pend_d      = 1'b0;
    mse_p_d     = mse_p_q;
    div_p_d     = div_p_q;
    le_p_d      = le_p_q;
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    mse_d       = mse_q;
    mse_valid_d = 1'b0;
    blk_cnt_d   = blk_cnt_q;

    // Threshold comparisons happen on the block-end cycle so thr_in is sampled there.
    if (v1_q) begin
      if (&scnt_q) begin
        acc_d   = '0;
        scnt_d  = '0;
        pend_d  = 1'b1;
        mse_p_d = blk_mse;
        div_p_d = (blk_mse > DIV_LIM);
        le_p_d  = (blk_mse <= thr_in);
      end else begin
        acc_d  = blk_sum;
        scnt_d = scnt_q + 1'b1;
      end
    end

    if (pend_q) begin
      mse_d       = mse_p_q;
      mse_valid_d = 1'b1;
      blk_cnt_d   = blk_cnt_q + 8'd1;
      case (state_q)
        ST_ACQ: begin
          if (div_p_q) begin
            state_d = ST_DIV;
          end else if (le_p_q) begin
            if (good_cnt_q + 4'd1 == 4'(HOLD)) begin
              state_d    = ST_CONV;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        ST_CONV: begin
          if (div_p_q) begin
            state_d = ST_DIV;
          end else if (!le_p_q) begin
            state_d    = ST_ACQ;
            good_cnt_d = '0;
          end
        end
        default: state_d = ST_DIV;
      endcase
    end

    // Restart drops everything in flight, including a block that is just completing.
    if (restart) begin
      v1_d        = 1'b0;
      acc_d       = '0;
      scnt_d      = '0;
      pend_d      = 1'b0;
      good_cnt_d  = '0;
      state_d     = ST_ACQ;
      mse_d       = mse_q;
      mse_valid_d = 1'b0;
      blk_cnt_d   = blk_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      sq_q        <= '0;
      acc_q       <= '0;
      scnt_q      <= '0;
      pend_q      <= 1'b0;
      mse_p_q     <= '0;
      div_p_q     <= 1'b0;
      le_p_q      <= 1'b0;
      state_q     <= ST_ACQ;
      good_cnt_q  <= '0;
      mse_q       <= '0;
      mse_valid_q <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      v1_q        <= v1_d;
      sq_q        <= sq_d;
      acc_q       <= acc_d;
      scnt_q      <= scnt_d;
      pend_q      <= pend_d;
      mse_p_q     <= mse_p_d;
      div_p_q     <= div_p_d;
      le_p_q      <= le_p_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      mse_q       <= mse_d;
      mse_valid_q <= mse_valid_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign mse_out   = mse_q;
  assign mse_valid = mse_valid_q;
  assign converged = (state_q == ST_CONV);
  assign diverged  = (state_q == ST_DIV);
  assign state_out = state_q;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_lms_err_monitor.sv
// Directed bench for lms_err_monitor: block MSE values, pulse latency, FSM transitions,
// gaps, restart, mid-block reset and block counter wrap.
module tb_lms_err_monitor;
  logic        clk = 1'b0;
  logic        reset, en, restart;
  logic [15:0] e_in;
  logic [31:0] thr_in;
  logic [31:0] mse_out;
  logic        mse_valid, converged, diverged;
  logic [1:0]  state_out;
  logic [7:0]  blk_cnt;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int exp_blk = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  lms_err_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .restart   (restart),
    .e_in      (e_in),
    .thr_in    (thr_in),
    .mse_out   (mse_out),
    .mse_valid (mse_valid),
    .converged (converged),
    .diverged  (diverged),
    .state_out (state_out),
    .blk_cnt   (blk_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every mse_valid pulse must match the next expected block MSE.
  always @(posedge clk) begin
    #1;
    if (mse_valid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) check("spurious_valid", {63'd0, mse_valid}, 64'd0);
      else check("mse_pulse", {32'd0, mse_out}, {32'd0, exp_q.pop_front()});
    end
  end

  task automatic tick(input logic [15:0] e, input logic v, input logic rs = 1'b0);
    e_in    = e;
    en      = v;
    restart = rs;
    @(posedge clk);
    #2;
    restart = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(16'h7fff, 1'b0);
  endtask

  task automatic push_exp(input logic [15:0] e);
    longint s;
    s = longint'($signed(e));
    exp_q.push_back(32'(s * s));
    exp_pulses++;
    exp_blk++;
  endtask

  task automatic blk(input logic [15:0] e);
    push_exp(e);
    repeat (16) tick(e, 1'b1);
  endtask

  task automatic chk_blk(input string tag);
    check(tag, {56'd0, blk_cnt}, {56'd0, 8'(exp_blk)});
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; restart = 1'b0; e_in = 16'd100; thr_in = 32'd1000;
    repeat (3) @(posedge clk);
    #2;
    check("rst_mse", {32'd0, mse_out}, 64'd0);
    check("rst_valid", {63'd0, mse_valid}, 64'd0);
    check("rst_conv", {63'd0, converged}, 64'd0);
    check("rst_div", {63'd0, diverged}, 64'd0);
    check("rst_state", {62'd0, state_out}, 64'd0);
    check("rst_blk", {56'd0, blk_cnt}, 64'd0);
    reset = 1'b0;

    // 15 samples plus gaps must not complete a block; the 16th does.
    repeat (15) tick(16'd100, 1'b1);
    idle(3);
    chk_blk("no_early_blk");
    push_exp(16'd100);
    tick(16'd100, 1'b1);
    idle(2);
    chk_blk("first_blk");

    // Constant error with exact pulse latency and width.
    reset = 1'b1; tick(16'd0, 1'b0); reset = 1'b0; exp_blk = 0;
    blk(16'd10);
    tick(16'd0, 1'b0);
    check("lat_t1", {63'd0, mse_valid}, 64'd0);
    tick(16'd0, 1'b0);
    check("lat_t2", {63'd0, mse_valid}, 64'd1);
    check("const_mse", {32'd0, mse_out}, 64'd100);
    chk_blk("const_blk");
    check("const_state", {62'd0, state_out}, 64'd0);
    tick(16'd0, 1'b0);
    check("pulse_width", {63'd0, mse_valid}, 64'd0);

    // Convergence after HOLD good blocks, back to back, then drop back to ACQ.
    tick(16'd0, 1'b0, 1'b1);
    check("rst_hold_mse", {32'd0, mse_out}, 64'd100);
    chk_blk("rst_hold_blk");
    for (int b = 0; b < 4; b++) blk(16'hfff6);
    idle(1);
    check("conv_early", {63'd0, converged}, 64'd0);
    idle(1);
    check("conv_valid", {63'd0, mse_valid}, 64'd1);
    check("conv_set", {63'd0, converged}, 64'd1);
    check("conv_state", {62'd0, state_out}, 64'd1);
    blk(16'd40);
    idle(2);
    check("unconv_state", {62'd0, state_out}, 64'd0);
    check("unconv_flag", {63'd0, converged}, 64'd0);
    chk_blk("unconv_blk");

    // A bad block in ACQ clears the good-block run.
    tick(16'd0, 1'b0, 1'b1);
    for (int b = 0; b < 3; b++) blk(16'd10);
    blk(16'd40);
    for (int b = 0; b < 3; b++) blk(16'd10);
    idle(2);
    check("hold_reset", {62'd0, state_out}, 64'd0);
    blk(16'd10);
    idle(2);
    check("hold_conv", {62'd0, state_out}, 64'd1);

    // Divergence is absorbing until restart.
    blk(16'h8000);
    idle(2);
    check("div_mse", {32'd0, mse_out}, 64'd1073741824);
    check("div_flag", {63'd0, diverged}, 64'd1);
    check("div_state", {62'd0, state_out}, 64'd2);
    check("div_conv", {63'd0, converged}, 64'd0);
    blk(16'd0);
    idle(2);
    check("div_sticky", {62'd0, state_out}, 64'd2);
    check("div_zero_mse", {32'd0, mse_out}, 64'd0);
    tick(16'd0, 1'b0, 1'b1);
    idle(1);
    check("div_restart", {62'd0, state_out}, 64'd0);
    check("div_restart_flag", {63'd0, diverged}, 64'd0);
    chk_blk("div_restart_blk");

    // Gaps between samples, with junk on e_in while en is low.
    push_exp(16'd20);
    for (int i = 0; i < 16; i++) begin
      tick(16'd20, 1'b1);
      if (i < 15) tick(16'h7fff, 1'b0);
    end
    idle(2);
    check("gap_mse", {32'd0, mse_out}, 64'd400);
    chk_blk("gap_blk");

    // Restart mid-block discards the partial block and the same-cycle sample.
    repeat (8) tick(16'd7, 1'b1);
    tick(16'd7, 1'b1, 1'b1);
    blk(16'd5);
    idle(2);
    check("rs_mid_mse", {32'd0, mse_out}, 64'd25);
    chk_blk("rs_mid_blk");

    // Restart on the block-end cycle suppresses that block.
    repeat (16) tick(16'd9, 1'b1);
    tick(16'd0, 1'b0, 1'b1);
    idle(3);
    chk_blk("rs_end_blk");
    check("rs_end_mse", {32'd0, mse_out}, 64'd25);

    // Reset mid-block loses the partial accumulation.
    repeat (8) tick(16'd7, 1'b1);
    reset = 1'b1; tick(16'd7, 1'b1); reset = 1'b0; exp_blk = 0;
    check("rst_mid_mse", {32'd0, mse_out}, 64'd0);
    chk_blk("rst_mid_blk");
    blk(16'd3);
    idle(2);
    check("rst_mid_new", {32'd0, mse_out}, 64'd9);
    chk_blk("rst_mid_cnt");

    // 256 back-to-back blocks wrap the block counter.
    repeat (256) blk(16'd1);
    idle(2);
    chk_blk("wrap_blk");
    check("wrap_mse", {32'd0, mse_out}, 64'd1);

    idle(3);
    check("pulse_count", 64'(pulses), 64'(exp_pulses));
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lms_err_monitor.md
# lms_err_monitor

Convergence monitor placed directly downstream of the LMS adaptive FIR stage. It consumes the filter's W2-bit signed error sample stream and squares each sample. It accumulates the squares over fixed blocks of N = 2^LOGN samples and publishes the block mean-squared error. A three-state FSM declares the filter acquiring, converged or diverged, so control logic and test benches can gate on adaptation status.

## Interface
- W2, 16: error sample width (signed)
- LOGN, 4: log2 of block length N (default N = 16)
- HOLD, 4: consecutive good blocks required to declare convergence (1..15)
- DIV_LIM, 2^28: MSE above which the filter is declared diverged (2*W2-bit unsigned)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  error sample valid; one sample per cycle while high
- restart  in  1  synchronous restart of monitoring (clears accumulator, counters, FSM to ACQ)
- e_in  in  W2  signed error sample from LMS stage
- thr_in  in  2*W2  unsigned convergence threshold; sampled at each block end
- mse_out  out  2*W2  last block mean-squared error, unsigned
- mse_valid  out  1  one-cycle pulse when mse_out updates
- converged  out  1  high while FSM in CONV
- diverged  out  1  high while FSM in DIV (sticky)
- state_out  out  2  FSM state: 00 ACQ, 01 CONV, 10 DIV
- blk_cnt  out  8  completed-block count, wraps 255 -> 0

## Operation
- Stage 1: when en=1, sq = e_in*e_in (2*W2 bits, unsigned, exact; max 2^30 for -32768). Valid bit v1 registered with sq.
- Stage 2: when v1=1, acc += sq. acc is 2*W2+LOGN bits wide and never overflows. Sample counter scnt (LOGN bits) increments per v1.
- Block end: v1=1 and scnt = N-1. mse = (acc + sq) >> LOGN, truncated to 2*W2 bits, which is lossless. acc is reloaded to 0 and scnt wraps to 0. mse_out is loaded, mse_valid pulses, and blk_cnt increments.
- FSM, evaluated only at block end, on the new mse:
  - ACQ: if mse > DIV_LIM, go to DIV. Else if mse <= thr_in, good_cnt++ and go to CONV when good_cnt reaches HOLD. Else good_cnt = 0.
  - CONV: if mse > DIV_LIM, go to DIV. Else if mse > thr_in, go to ACQ with good_cnt = 0. Else stay in CONV.
  - DIV: absorbing. Only reset or restart leaves it.
- restart=1: acc, scnt, v1, good_cnt go to 0 and FSM goes to ACQ. The in-flight sample and any same-cycle en sample are discarded. mse_out and blk_cnt hold their values. restart has priority over everything except reset.
- en=0 cycles are gaps. They do not advance scnt, and a block may span any number of gaps.
- thr_in is only looked at on block-end cycles. Changes between block ends have no effect.

## Timing
- Reset values: mse_out=0, mse_valid=0, converged=0, diverged=0, state_out=00, blk_cnt=0. Internal acc, scnt, good_cnt, v1 are also 0.
- Latency: if the N-th sample of a block is presented with en=1 at edge t, mse_valid=1 and mse_out are updated after edge t+2. state_out, converged and diverged reflect that block after the same edge t+2.
- Throughput: one sample per cycle, with no bubble between blocks.
- mse_valid is high for exactly one cycle per block.
- Reset asserted mid-block: all state returns to reset values on that edge. A partially accumulated block is lost.
- restart and block end in the same cycle: restart wins. No mse_valid, and blk_cnt is unchanged.

## Test plan
- Reset: hold reset 3 cycles with en=1, e_in=100 -> all outputs 0. First block completes only after 16 samples following reset release.
- Constant error: 16 samples of e_in=10, en=1, thr_in=1000 -> mse_out=100 and a single mse_valid pulse 2 cycles after the 16th sample. blk_cnt=1, state ACQ.
- Convergence: 64 samples of e_in=-10 with thr_in=1000 -> converged=1 in the mse_valid cycle of block 4. Next block of e_in=40 (mse=1600) -> state ACQ, converged=0.
- Divergence: 16 samples e_in=-32768 -> mse_out=1073741824 (> 2^28), diverged=1, state 10. A following block of e_in=0 keeps DIV. Then restart -> ACQ.
- Gaps and restart: 16 samples of e_in=20 with en toggling 1/0 -> mse_out=400 after 31 cycles. Separately, 8 samples, then restart, then 16 samples of e_in=5 -> mse_out=25, blk_cnt up by 1 only.
- Wrap: 256 blocks of e_in=1 -> blk_cnt returns to 0 and mse_out=1 throughout.
